// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings plus the data-phase select and default-slave state types
// used by the slave multiplexer.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] DEF_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Who owns the current data phase; the slave index is held alongside.
  typedef enum logic [1:0] {
    DSEL_IDLE = 2'd0,
    DSEL_SLV  = 2'd1,
    DSEL_DEF  = 2'd2
  } dsel_t;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_t;

endpackage

// File: rtl/ahb3lite_default_slave.sv
// Default slave for unmapped addresses: answers every accepted transfer with the
// two-cycle AHB ERROR response, back-to-back capable.
module ahb3lite_default_slave
  import ahb3lite_pkg::*;
#(
  parameter logic [31:0] RDATA = DEF_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic [31:0] hrdata_o
);

  def_state_t  state_q;
  logic        hreadyout_q;
  logic        hresp_q;
  logic [31:0] hrdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DEF_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
    end else begin
      case (state_q)
        DEF_ERR1: begin
          state_q     <= DEF_ERR2;
          hreadyout_q <= 1'b1;
        end
        // IDLE and ERR2 both accept a new unmapped transfer when the bus is ready.
        default: begin
          if (hready_i && sel_i) begin
            state_q     <= DEF_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
            hrdata_q    <= RDATA;
          end else begin
            state_q     <= DEF_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
          end
        end
      endcase
    end
  end

  assign hreadyout_o = hreadyout_q;
  assign hresp_o     = hresp_q;
  assign hrdata_o    = hrdata_q;

endmodule

// File: rtl/ahb3lite_slave_mux.sv
// N-way AHB3-lite decoder and response mux with table-driven base/mask decode,
// built-in error slave, stall watchdog and saturating error counter.
module ahb3lite_slave_mux
  import ahb3lite_pkg::*;
#(
  parameter int unsigned        NSLV      = 2,
  parameter logic [NSLV*32-1:0] SLV_BASE  = {32'hF000_0000, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK  = {32'hF000_0000, 32'h0000_0000},
  parameter logic [31:0]        DEF_RDATA = DEF_RDATA_DEFAULT,
  parameter int unsigned        TO_WIDTH  = 16,
  parameter int unsigned        ERR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [31:0]          M_HADDR,
  input  logic [1:0]           M_HTRANS,
  output logic                 M_HREADY,
  output logic                 M_HRESP,
  output logic [31:0]          M_HRDATA,
  output logic [NSLV-1:0]      S_HSEL,
  input  logic [NSLV-1:0]      S_HREADYOUT,
  input  logic [NSLV-1:0]      S_HRESP,
  input  logic [NSLV*32-1:0]   S_HRDATA,
  input  logic [TO_WIDTH-1:0]  TO_CYCLES,
  input  logic                 STAT_CLR,
  output logic                 TIMEOUT,
  output logic [2:0]           TO_IDX,
  output logic [ERR_WIDTH-1:0] ERR_CNT
);

  localparam int unsigned IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic            active;
  logic [NSLV-1:0] hit;
  logic            win_hit;
  logic [IDXW-1:0] win_idx;

  assign active = (M_HTRANS == HTRANS_NONSEQ) || (M_HTRANS == HTRANS_SEQ);

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_hit
    assign hit[gi] = active && ((M_HADDR & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32]);
  end

  // Isolating the lowest set bit gives lowest-index priority directly.
  assign S_HSEL  = hit & (~hit + NSLV'(1));
  assign win_hit = |hit;

  always_comb begin
    win_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = IDXW'(i);
    end
  end

  dsel_t           dsel_q, dsel_d;
  logic [IDXW-1:0] dsel_idx_q, dsel_idx_d;

  always_comb begin
    dsel_d     = dsel_q;
    dsel_idx_d = dsel_idx_q;
    if (M_HREADY) begin
      if (!active) begin
        dsel_d     = DSEL_IDLE;
        dsel_idx_d = '0;
      end else if (win_hit) begin
        dsel_d     = DSEL_SLV;
        dsel_idx_d = win_idx;
      end else begin
        dsel_d     = DSEL_DEF;
        dsel_idx_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      dsel_q     <= DSEL_IDLE;
      dsel_idx_q <= '0;
    end else begin
      dsel_q     <= dsel_d;
      dsel_idx_q <= dsel_idx_d;
    end
  end

  logic        def_hreadyout;
  logic        def_hresp;
  logic [31:0] def_hrdata;

  ahb3lite_default_slave #(
    .RDATA (DEF_RDATA)
  ) u_def_slave (
    .clk_i       (CLK),
    .rst_ni      (RESETn),
    .sel_i       (active && !win_hit),
    .hready_i    (M_HREADY),
    .hreadyout_o (def_hreadyout),
    .hresp_o     (def_hresp),
    .hrdata_o    (def_hrdata)
  );

  always_comb begin
    M_HREADY = 1'b1;
    M_HRESP  = HRESP_OKAY;
    M_HRDATA = '0;
    case (dsel_q)
      DSEL_SLV: begin
        for (int i = 0; i < NSLV; i++) begin
          if (dsel_idx_q == IDXW'(i)) begin
            M_HREADY = S_HREADYOUT[i];
            M_HRESP  = S_HRESP[i];
            M_HRDATA = S_HRDATA[i*32 +: 32];
          end
        end
      end
      DSEL_DEF: begin
        M_HREADY = def_hreadyout;
        M_HRESP  = def_hresp;
        M_HRDATA = def_hrdata;
      end
      default: ;
    endcase
  end

  // Watchdog only observes; it never feeds back into the bus path.
  logic                stall;
  logic                to_hit;
  logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  assign stall = (dsel_q == DSEL_SLV) && !M_HREADY;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (M_HREADY) begin
      wd_cnt_d = '0;
    end else if (stall) begin
      if (!((TO_CYCLES != '0) && (wd_cnt_q == TO_CYCLES)) && (wd_cnt_q != '1)) begin
        wd_cnt_d = wd_cnt_q + TO_WIDTH'(1);
      end
    end
  end

  assign to_hit = stall && (TO_CYCLES != '0) && (wd_cnt_d == TO_CYCLES);

  logic                 timeout_q;
  logic [2:0]           to_idx_q;
  logic [ERR_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      to_idx_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (STAT_CLR) begin
        timeout_q <= 1'b0;
        to_idx_q  <= '0;
        err_cnt_q <= '0;
      end else begin
        if (to_hit && !timeout_q) begin
          timeout_q <= 1'b1;
          to_idx_q  <= 3'(dsel_idx_q);
        end
        if (M_HREADY && M_HRESP && (err_cnt_q != '1)) begin
          err_cnt_q <= err_cnt_q + ERR_WIDTH'(1);
        end
      end
    end
  end

  assign TIMEOUT = timeout_q;
  assign TO_IDX  = to_idx_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ahb3lite_slave_mux.sv
// Randomised bench for the AHB3-lite slave mux: a transfer-level model predicts every
// response each cycle, and a few hand-derived expectations pin the model.
module tb_ahb3lite_slave_mux;
  import ahb3lite_pkg::*;

  localparam int NS     = 3;
  localparam int TOW    = 8;
  localparam int ERW    = 2;
  localparam int ERRMAX = (1 << ERW) - 1;
  localparam logic [31:0] DEFD = 32'hDEAD_BEEF;

  logic              CLK = 1'b0;
  logic              RESETn = 1'b0;
  logic [31:0]       M_HADDR = '0;
  logic [1:0]        M_HTRANS = HTRANS_IDLE;
  logic              M_HREADY;
  logic              M_HRESP;
  logic [31:0]       M_HRDATA;
  logic [NS-1:0]     S_HSEL;
  logic [NS-1:0]     S_HREADYOUT = '1;
  logic [NS-1:0]     S_HRESP = '0;
  logic [NS*32-1:0]  S_HRDATA = {32'h1234_5678, 32'hB1B1_1111, 32'hA0A0_0000};
  logic [TOW-1:0]    TO_CYCLES = '0;
  logic              STAT_CLR = 1'b0;
  logic              TIMEOUT;
  logic [2:0]        TO_IDX;
  logic [ERW-1:0]    ERR_CNT;

  ahb3lite_slave_mux #(
    .NSLV      (NS),
    .SLV_BASE  ({32'h2000_0000, 32'hF000_0000, 32'h0000_0000}),
    .SLV_MASK  ({32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000}),
    .DEF_RDATA (DEFD),
    .TO_WIDTH  (TOW),
    .ERR_WIDTH (ERW)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .M_HADDR     (M_HADDR),
    .M_HTRANS    (M_HTRANS),
    .M_HREADY    (M_HREADY),
    .M_HRESP     (M_HRESP),
    .M_HRDATA    (M_HRDATA),
    .S_HSEL      (S_HSEL),
    .S_HREADYOUT (S_HREADYOUT),
    .S_HRESP     (S_HRESP),
    .S_HRDATA    (S_HRDATA),
    .TO_CYCLES   (TO_CYCLES),
    .STAT_CLR    (STAT_CLR),
    .TIMEOUT     (TIMEOUT),
    .TO_IDX      (TO_IDX),
    .ERR_CNT     (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  logic [31:0] base_t [NS] = '{32'h0000_0000, 32'hF000_0000, 32'h2000_0000};
  logic [31:0] mask_t [NS] = '{32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000};

  int checks = 0;
  int errors = 0;

  // Model state: target of the transfer in data phase (-1 none, NS = default slave).
  int m_tgt = -1, m_ph = 1, m_stall = 0, m_toidx = 0, m_err = 0;
  bit m_to = 1'b0;
  int n_tgt = -1, n_ph = 1, n_stall = 0, n_toidx = 0, n_err = 0;
  bit n_to = 1'b0;

  // Hand-computed expectations for the current cycle, owned by the stimulus process.
  string       pin_name [8];
  int          pin_sig  [8];
  logic [31:0] pin_val  [8];
  int          pin_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sig_val(input int s);
    case (s)
      0:       return 32'(S_HSEL);
      1:       return 32'(M_HREADY);
      2:       return 32'(M_HRESP);
      3:       return M_HRDATA;
      4:       return 32'(TIMEOUT);
      5:       return 32'(TO_IDX);
      default: return 32'(ERR_CNT);
    endcase
  endfunction

  always @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_tgt = -1; m_ph = 1; m_stall = 0; m_to = 1'b0; m_toidx = 0; m_err = 0;
    end else begin
      m_tgt = n_tgt; m_ph = n_ph; m_stall = n_stall; m_to = n_to; m_toidx = n_toidx; m_err = n_err;
    end
  end

  always @(negedge CLK) begin : cmp
    int          win;
    bit          act, slv, e_rdy, e_resp;
    logic [31:0] e_data;
    logic [NS-1:0] e_hsel;
    act = (M_HTRANS == HTRANS_NONSEQ) || (M_HTRANS == HTRANS_SEQ);
    win = -1;
    for (int i = NS - 1; i >= 0; i--)
      if (act && ((M_HADDR & mask_t[i]) == base_t[i])) win = i;
    e_hsel = '0;
    if (win >= 0) e_hsel[win] = 1'b1;
    slv = (m_tgt >= 0) && (m_tgt < NS);
    if (slv) begin
      e_rdy = S_HREADYOUT[m_tgt]; e_resp = S_HRESP[m_tgt]; e_data = S_HRDATA[32*m_tgt +: 32];
    end else if (m_tgt == NS) begin
      e_rdy = (m_ph == 2); e_resp = 1'b1; e_data = DEFD;
    end else begin
      e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
    end
    chk("hsel",    32'(S_HSEL),   32'(e_hsel));
    chk("hready",  32'(M_HREADY), 32'(e_rdy));
    chk("hresp",   32'(M_HRESP),  32'(e_resp));
    chk("hrdata",  M_HRDATA,      e_data);
    chk("timeout", 32'(TIMEOUT),  32'(m_to));
    chk("to_idx",  32'(TO_IDX),   32'(m_toidx));
    chk("err_cnt", 32'(ERR_CNT),  32'(m_err));
    for (int k = 0; k < pin_n; k++)
      chk(pin_name[k], sig_val(pin_sig[k]), pin_val[k]);

    n_tgt = m_tgt; n_ph = m_ph; n_stall = m_stall; n_to = m_to; n_toidx = m_toidx; n_err = m_err;
    if (e_rdy) begin
      n_tgt = !act ? -1 : ((win >= 0) ? win : NS);
      n_ph = 1;
      n_stall = 0;
    end else if (m_tgt == NS) begin
      n_ph = 2;
    end else if (slv) begin
      n_stall = m_stall + 1;
    end
    if (!e_rdy && slv && (TO_CYCLES != 0) && (n_stall >= int'(TO_CYCLES)) && !m_to) begin
      n_to = 1'b1;
      n_toidx = m_tgt;
    end
    if (e_rdy && e_resp) n_err = (m_err < ERRMAX) ? m_err + 1 : ERRMAX;
    if (STAT_CLR) begin
      n_to = 1'b0; n_toidx = 0; n_err = 0;
    end
  end

  task automatic pin(input string nm, input int s, input logic [31:0] v);
    pin_name[pin_n] = nm;
    pin_sig[pin_n]  = s;
    pin_val[pin_n]  = v;
    pin_n++;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    pin_n = 0;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a);
    M_HTRANS = tr;
    M_HADDR  = a;
  endtask

  task automatic settle();
    S_HREADYOUT = '1;
    S_HRESP = '0;
    STAT_CLR = 1'b0;
    drive(HTRANS_IDLE, 32'h0);
    repeat (3) cyc();
  endtask

  task automatic rnd_cycles(input int n, input bit do_rst);
    for (int k = 0; k < n; k++) begin
      RESETn = !(do_rst && (k == n / 2));
      M_HTRANS = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: M_HADDR = {4'h0, 28'($urandom)};
        1: M_HADDR = {16'hF000, 16'($urandom)};
        2: M_HADDR = {4'h2, 28'($urandom)};
        3: M_HADDR = {12'hF00, 4'($urandom_range(1, 15)), 16'($urandom)};
        default: M_HADDR = $urandom;
      endcase
      for (int i = 0; i < NS; i++) begin
        S_HREADYOUT[i] = ($urandom_range(0, 3) != 0);
        S_HRESP[i] = ($urandom_range(0, 7) == 0);
        S_HRDATA[32*i +: 32] = $urandom;
      end
      STAT_CLR = ($urandom_range(0, 19) == 0);
      cyc();
    end
    RESETn = 1'b1;
  endtask

  initial begin
    pin("rst_hready", 1, 32'h1);
    pin("rst_hresp", 2, 32'h0);
    pin("rst_hrdata", 3, 32'h0);
    pin("rst_timeout", 4, 32'h0);
    pin("rst_err", 6, 32'h0);
    cyc(); cyc(); cyc();
    RESETn = 1'b1;
    cyc(); cyc();

    // Zero-wait read from slave 2.
    drive(HTRANS_NONSEQ, 32'h2000_0010); pin("t1_hsel", 0, 32'h4);
    cyc(); drive(HTRANS_IDLE, 32'h0);
    pin("t1_hrdata", 3, 32'h1234_5678); pin("t1_hresp", 2, 32'h0);

    // Responses follow the registered select, not the current address.
    cyc(); drive(HTRANS_NONSEQ, 32'h0400_0000); pin("t2_hsel0", 0, 32'h1);
    cyc(); drive(HTRANS_NONSEQ, 32'hF000_0004); pin("t2_hsel1", 0, 32'h2);
    pin("t2_hrdata0", 3, 32'hA0A0_0000);
    cyc(); drive(HTRANS_IDLE, 32'h0); pin("t2_hrdata1", 3, 32'hB1B1_1111);

    // Unmapped transfer: two-cycle ERROR.
    cyc(); drive(HTRANS_NONSEQ, 32'hF001_0000); pin("t3_hsel", 0, 32'h0);
    cyc(); drive(HTRANS_IDLE, 32'h0);
    pin("t3_err1_rdy", 1, 32'h0); pin("t3_err1_resp", 2, 32'h1);
    pin("t3_err1_data", 3, DEFD); pin("t3_err_before", 6, 32'h0);
    cyc(); pin("t3_err2_rdy", 1, 32'h1); pin("t3_err2_resp", 2, 32'h1); pin("t3_err2_data", 3, DEFD);
    cyc(); pin("t3_err_after", 6, 32'h1); pin("t3_idle_resp", 2, 32'h0);

    // Watchdog on slave 1.
    cyc(); TO_CYCLES = 8'd5; drive(HTRANS_NONSEQ, 32'hF000_0004);
    cyc(); drive(HTRANS_IDLE, 32'h0); S_HREADYOUT[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) drive(HTRANS_NONSEQ, 32'h2000_0000);
      if (k == 5) pin("t4_to_early", 4, 32'h0);
      if (k == 6) begin pin("t4_to_set", 4, 32'h1); pin("t4_to_idx", 5, 32'h1); end
      if (k == 7) begin pin("t4_stall_rdy", 1, 32'h0); pin("t4_hold_data", 3, 32'hB1B1_1111); end
      cyc();
    end
    S_HREADYOUT[1] = 1'b1; pin("t4_release", 1, 32'h1); pin("t4_sticky", 4, 32'h1);
    cyc(); drive(HTRANS_IDLE, 32'h0); STAT_CLR = 1'b1; pin("t4_next_data", 3, 32'h1234_5678);
    cyc(); STAT_CLR = 1'b0;
    pin("t4_clr_to", 4, 32'h0); pin("t4_clr_idx", 5, 32'h0); pin("t4_clr_err", 6, 32'h0);
    TO_CYCLES = 8'd0;

    // Back-to-back unmapped transfers saturate the counter.
    cyc();
    for (int k = 0; k < 10; k++) begin
      drive(HTRANS_NONSEQ, 32'hF001_0000);
      cyc();
    end
    drive(HTRANS_IDLE, 32'h0);
    cyc(); pin("t5_sat", 6, 32'h3);
    drive(HTRANS_NONSEQ, 32'hF001_0000);
    cyc(); drive(HTRANS_IDLE, 32'h0);
    cyc(); STAT_CLR = 1'b1; pin("t5_err2_rdy", 1, 32'h1);
    cyc(); STAT_CLR = 1'b0; pin("t5_clr_wins", 6, 32'h0);

    // Reset during the first ERROR cycle.
    cyc(); drive(HTRANS_NONSEQ, 32'hF001_0000);
    cyc(); drive(HTRANS_IDLE, 32'h0);
    #1 RESETn = 1'b0;
    pin("t6_rst_rdy", 1, 32'h1); pin("t6_rst_resp", 2, 32'h0);
    cyc(); RESETn = 1'b1; drive(HTRANS_NONSEQ, 32'h0000_0000); pin("t6_hsel", 0, 32'h1);
    cyc(); drive(HTRANS_IDLE, 32'h0); pin("t6_data", 3, 32'hA0A0_0000);
    cyc();

    // Randomised traffic with watchdog enabled, then disabled.
    TO_CYCLES = 8'd3;
    rnd_cycles(3000, 1'b1);
    settle();
    TO_CYCLES = 8'd0;
    rnd_cycles(1500, 1'b0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
